// File: rtl/unified_mem_arbiter.sv
// Purpose : arbitrates one single-ported memory between instruction fetch (IF) and load/store (MEM).
// Latency : a request granted in cycle t completes (ready pulse) in cycle t+LAT; port idle again at t+LAT+1.
// Backpr. : requesters hold req until their ready pulse; stall_if/stall_mem flag every waiting cycle.
//
// Ports
//   clk, rst                      rising-edge clock, synchronous active-high reset
//   if_req/if_addr/if_flush       fetch request, address, and abandon-fetch (branch redirect)
//   if_rdata/if_ready/stall_if    fetch data, one-cycle completion pulse, fetch stall
//   mem_req/mem_we/mem_addr/mem_wdata  load/store request, write select, address, store data
//   mem_rdata/mem_ready/stall_mem load data, one-cycle completion pulse, load/store stall
//   ram_en/ram_we/ram_addr/ram_wdata/ram_rdata  memory port; read data valid LAT cycles after ram_en
module unified_mem_arbiter #(
  parameter int LAT = 2,
  parameter int AW  = 32,
  parameter int DW  = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  input  logic          if_flush,
  output logic [DW-1:0] if_rdata,
  output logic          if_ready,
  output logic          stall_if,
  input  logic          mem_req,
  input  logic          mem_we,
  input  logic [AW-1:0] mem_addr,
  input  logic [DW-1:0] mem_wdata,
  output logic [DW-1:0] mem_rdata,
  output logic          mem_ready,
  output logic          stall_mem,
  output logic          ram_en,
  output logic          ram_we,
  output logic [AW-1:0] ram_addr,
  output logic [DW-1:0] ram_wdata,
  input  logic [DW-1:0] ram_rdata
);

  localparam int            CW    = $clog2(LAT + 1);
  localparam logic [CW-1:0] LAT_C = CW'(LAT);
  localparam logic [CW-1:0] ONE_C = CW'(1);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    BUSY_IF  = 2'd1,
    BUSY_MEM = 2'd2
  } state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic          kill;

  logic grant_mem;
  logic grant_if;
  logic done;

  // Grant is decided in the same cycle the request is seen in IDLE so that the
  // port enable goes out without an extra bubble. MEM wins because it belongs to
  // the older instruction; a flush in IDLE only blocks the fetch grant this cycle.
  always_comb begin
    grant_mem = 1'b0;
    grant_if  = 1'b0;
    done      = 1'b0;
    if (state == IDLE) begin
      grant_mem = mem_req;
      grant_if  = ~mem_req & if_req & ~if_flush;
    end else begin
      done = (cnt == LAT_C);
    end
  end

  // The memory port and the completion pulses must react within the cycle
  // (grant and flush are both same-cycle events), so they are decoded from the
  // registered state rather than registered themselves. Everything is gated by
  // rst because a reset may land while the FSM is still mid-access.
  always_comb begin
    ram_en    = 1'b0;
    ram_we    = 1'b0;
    ram_addr  = '0;
    ram_wdata = '0;
    if (!rst) begin
      if (grant_mem) begin
        ram_en    = 1'b1;
        ram_we    = mem_we;
        ram_addr  = mem_addr;
        ram_wdata = mem_wdata;
      end else if (grant_if) begin
        ram_en    = 1'b1;
        ram_addr  = if_addr;
      end
    end
  end

  always_comb begin
    // A flush arriving in the completion cycle itself is not yet in kill, so it
    // is folded in directly to suppress the pulse.
    if_ready  = ~rst & done & (state == BUSY_IF) & ~kill & ~if_flush;
    mem_ready = ~rst & done & (state == BUSY_MEM);
    if_rdata  = if_ready  ? ram_rdata : '0;
    mem_rdata = mem_ready ? ram_rdata : '0;
    stall_if  = ~rst & if_req  & ~if_ready;
    stall_mem = ~rst & mem_req & ~mem_ready;
  end

  // cnt runs 1..LAT inside a BUSY state and is cleared on the way back to IDLE,
  // so it never needs to wrap.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
      kill  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          kill <= 1'b0;
          if (grant_mem) begin
            state <= BUSY_MEM;
            cnt   <= ONE_C;
          end else if (grant_if) begin
            state <= BUSY_IF;
            cnt   <= ONE_C;
          end
        end
        BUSY_IF: begin
          // Sticky: once a redirect is seen the fetched word is stale, but the
          // port access still runs to completion.
          if (if_flush) begin
            kill <= 1'b1;
          end
          if (cnt == LAT_C) begin
            state <= IDLE;
            cnt   <= '0;
            kill  <= 1'b0;
          end else begin
            cnt <= cnt + ONE_C;
          end
        end
        BUSY_MEM: begin
          if (cnt == LAT_C) begin
            state <= IDLE;
            cnt   <= '0;
          end else begin
            cnt <= cnt + ONE_C;
          end
        end
        default: begin
          state <= IDLE;
          cnt   <= '0;
          kill  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_unified_mem_arbiter.sv
// Purpose : self-checking bench for unified_mem_arbiter (LAT=2 main instance, LAT=1/3 fetch sweeps).
// Latency : expected completions are scheduled at grant cycle + LAT by a port-occupancy model.
// Backpr. : requesters hold req until their ready pulse, then drop or present a new transaction.
module tb_unified_mem_arbiter;
  localparam int LAT = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at cycle %0d: got %h, expected %h", nm, cyc, act, exp);
    end
  endtask

  // Initial memory image: one known instruction at 0x10, a scrambled pattern elsewhere.
  function automatic logic [31:0] init_word(input logic [31:0] a);
    if (a == 32'h10) return 32'h0050_0093;
    return (a * 32'h9E37_79B1) ^ 32'hA5A5_0F0F;
  endfunction

  // ---------------- main DUT (LAT=2) ----------------
  logic        rst, if_req, if_flush, mem_req, mem_we;
  logic [31:0] if_addr, mem_addr, mem_wdata;
  logic [31:0] if_rdata, mem_rdata, ram_addr, ram_wdata, ram_rdata;
  logic        if_ready, stall_if, mem_ready, stall_mem, ram_en, ram_we;

  unified_mem_arbiter #(.LAT(LAT), .AW(32), .DW(32)) u_dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_flush(if_flush),
    .if_rdata(if_rdata), .if_ready(if_ready), .stall_if(stall_if),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ready(mem_ready), .stall_mem(stall_mem),
    .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
    .ram_rdata(ram_rdata)
  );

  // Memory behind the port: read data appears LAT cycles after ram_en, garbage otherwise.
  logic [31:0] ram_arr [2048];
  logic [31:0] rd_pipe [LAT];
  always @(posedge clk) begin
    if (ram_en && ram_we) ram_arr[ram_addr[12:2]] <= ram_wdata;
    rd_pipe[0] <= ram_en ? ram_arr[ram_addr[12:2]] : 32'hBAD0_BAD0;
    for (int i = 1; i < LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
  end
  assign ram_rdata = rd_pipe[LAT-1];

  // ---------------- reference model ----------------
  typedef struct {
    int          at;
    logic [31:0] dat;
    bit          chk_dat;
    bit          killed;
  } exp_t;

  exp_t        if_q[$];
  exp_t        mem_q[$];
  int          port_free   = 0;
  int          if_grant_at = -100;
  int          if_done_at  = -100;
  logic [31:0] ref_arr [2048];
  bit          e_en, e_we;
  logic [31:0] e_addr, e_wdata;
  bit          mon_on = 0;

  // The port is a resource busy for LAT+1 cycles per grant; a grant is possible
  // whenever the current cycle has reached the port-free cycle.
  task automatic model_step();
    exp_t e;
    e_en = 0; e_we = 0; e_addr = 0; e_wdata = 0;
    mon_on = 1;
    if (rst) begin
      if_q.delete(); mem_q.delete();
      port_free  = cyc + 1;
      if_done_at = -100;
      return;
    end
    if (if_flush && cyc > if_grant_at && cyc <= if_done_at && if_q.size() > 0) begin
      e = if_q[if_q.size()-1];
      e.killed = 1;
      if_q[if_q.size()-1] = e;
    end
    if (cyc >= port_free) begin
      if (mem_req) begin
        e_en = 1; e_we = mem_we; e_addr = mem_addr; e_wdata = mem_wdata;
        e.at = cyc + LAT; e.killed = 0; e.chk_dat = !mem_we;
        e.dat = ref_arr[mem_addr[12:2]];
        if (mem_we) ref_arr[mem_addr[12:2]] = mem_wdata;
        mem_q.push_back(e);
        port_free = cyc + LAT + 1;
      end else if (if_req && !if_flush) begin
        e_en = 1; e_addr = if_addr;
        e.at = cyc + LAT; e.killed = 0; e.chk_dat = 1;
        e.dat = ref_arr[if_addr[12:2]];
        if_q.push_back(e);
        if_grant_at = cyc; if_done_at = cyc + LAT;
        port_free = cyc + LAT + 1;
      end
    end
  endtask

  always @(posedge clk) begin
    #2;
    model_step();
  end

  // ---------------- monitor ----------------
  bit saw_if_rdy  = 0;
  bit saw_mem_rdy = 0;
  always @(negedge clk) begin
    bit xi, xm;
    if (mon_on) begin
      xi = (if_q.size() > 0 && if_q[0].at == cyc && !if_q[0].killed);
      xm = (mem_q.size() > 0 && mem_q[0].at == cyc);
      chk("ram_en", ram_en, e_en);
      chk("ram_we", ram_we, e_we);
      if (e_en || rst) chk("ram_addr", ram_addr, e_addr);
      if (e_we || rst) chk("ram_wdata", ram_wdata, e_wdata);
      chk("if_ready", if_ready, xi);
      chk("mem_ready", mem_ready, xm);
      chk("stall_if", stall_if, !rst && if_req && !xi);
      chk("stall_mem", stall_mem, !rst && mem_req && !xm);
      if (xi && if_ready) chk("if_rdata", if_rdata, if_q[0].dat);
      if (xm && mem_ready && mem_q[0].chk_dat) chk("mem_rdata", mem_rdata, mem_q[0].dat);
      if (rst) begin
        chk("rst_if_rdata", if_rdata, 0);
        chk("rst_mem_rdata", mem_rdata, 0);
      end
      if (if_q.size() > 0 && if_q[0].at <= cyc) void'(if_q.pop_front());
      if (mem_q.size() > 0 && mem_q[0].at <= cyc) void'(mem_q.pop_front());
    end
    saw_if_rdy  <= if_ready;
    saw_mem_rdy <= mem_ready;
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // ---------------- LAT=1 / LAT=3 back-to-back fetch sweeps ----------------
  logic        rst_b = 1'b1;
  logic        b_req [2], b_en [2], b_rdy [2], b_stall [2], b_mrdy [2], b_mstall [2], b_we [2];
  logic [31:0] b_addr [2], b_rdata [2], b_ramrd [2], b_ramaddr [2];
  logic [31:0] b_unused_wdata [2], b_unused_mrdata [2];

  unified_mem_arbiter #(.LAT(1), .AW(32), .DW(32)) u_lat1 (
    .clk(clk), .rst(rst_b),
    .if_req(b_req[0]), .if_addr(b_addr[0]), .if_flush(1'b0),
    .if_rdata(b_rdata[0]), .if_ready(b_rdy[0]), .stall_if(b_stall[0]),
    .mem_req(1'b0), .mem_we(1'b0), .mem_addr(32'h0), .mem_wdata(32'h0),
    .mem_rdata(b_unused_mrdata[0]), .mem_ready(b_mrdy[0]), .stall_mem(b_mstall[0]),
    .ram_en(b_en[0]), .ram_we(b_we[0]), .ram_addr(b_ramaddr[0]), .ram_wdata(b_unused_wdata[0]),
    .ram_rdata(b_ramrd[0])
  );

  unified_mem_arbiter #(.LAT(3), .AW(32), .DW(32)) u_lat3 (
    .clk(clk), .rst(rst_b),
    .if_req(b_req[1]), .if_addr(b_addr[1]), .if_flush(1'b0),
    .if_rdata(b_rdata[1]), .if_ready(b_rdy[1]), .stall_if(b_stall[1]),
    .mem_req(1'b0), .mem_we(1'b0), .mem_addr(32'h0), .mem_wdata(32'h0),
    .mem_rdata(b_unused_mrdata[1]), .mem_ready(b_mrdy[1]), .stall_mem(b_mstall[1]),
    .ram_en(b_en[1]), .ram_we(b_we[1]), .ram_addr(b_ramaddr[1]), .ram_wdata(b_unused_wdata[1]),
    .ram_rdata(b_ramrd[1])
  );

  logic [31:0] p1, p3 [3];
  always @(posedge clk) begin
    p1    <= b_en[0] ? init_word(b_ramaddr[0]) : 32'hBAD0_BAD0;
    p3[0] <= b_en[1] ? init_word(b_ramaddr[1]) : 32'hBAD0_BAD0;
    p3[1] <= p3[0];
    p3[2] <= p3[1];
  end
  assign b_ramrd[0] = p1;
  assign b_ramrd[1] = p3[2];

  int b_start = 0;
  int b_end [2] = '{0, 0};
  bit b_on = 0, b_done = 0;
  bit b_seen [2] = '{0, 0};

  initial begin
    b_req[0] = 0; b_req[1] = 0;
    b_addr[0] = 32'h400; b_addr[1] = 32'h400;
    tick(2);
    rst_b = 0;
    b_req[0] = 1; b_req[1] = 1;
    b_start = cyc;
    b_end[0] = cyc + 8 * 2;
    b_end[1] = cyc + 8 * 4;
    b_on = 1;
    while (b_req[0] || b_req[1]) begin
      tick(1);
      for (int k = 0; k < 2; k++) begin
        if (cyc >= b_end[k]) b_req[k] = 0;
        else if (b_seen[k]) b_addr[k] = b_addr[k] + 4;
      end
    end
    tick(4);
    b_done = 1;
  end

  // With req held from b_start, accesses repeat every LAT+1 cycles: one ram_en
  // at each grant, one ready LAT cycles later, fetching 0x400, 0x404, ...
  always @(negedge clk) begin
    int l, off;
    bit xe, xr;
    if (b_on) begin
      for (int k = 0; k < 2; k++) begin
        l   = (k == 0) ? 1 : 3;
        off = cyc - b_start;
        xe  = (cyc < b_end[k]) && (off % (l + 1) == 0);
        xr  = (off >= l) && ((off - l) % (l + 1) == 0) && (cyc - l < b_end[k]);
        chk(k == 0 ? "lat1_ram_en" : "lat3_ram_en", b_en[k], xe);
        chk(k == 0 ? "lat1_if_ready" : "lat3_if_ready", b_rdy[k], xr);
        chk(k == 0 ? "lat1_stall_if" : "lat3_stall_if", b_stall[k], b_req[k] && !xr);
        chk(k == 0 ? "lat1_ram_we" : "lat3_ram_we", b_we[k], 0);
        chk(k == 0 ? "lat1_mem_side" : "lat3_mem_side", {b_mrdy[k], b_mstall[k]}, 0);
        if (xr && b_rdy[k])
          chk(k == 0 ? "lat1_if_rdata" : "lat3_if_rdata", b_rdata[k],
              init_word(32'h400 + 32'((off - l) / (l + 1)) * 4));
        b_seen[k] <= b_rdy[k];
      end
    end
  end

  // ---------------- main stimulus ----------------
  initial begin
    rst = 1; if_req = 0; if_addr = 0; if_flush = 0;
    mem_req = 0; mem_we = 0; mem_addr = 0; mem_wdata = 0;
    for (int i = 0; i < 2048; i++) begin
      ref_arr[i] = init_word(32'(i) * 4);
      ram_arr[i] = init_word(32'(i) * 4);
    end
    tick(2);
    rst = 0;
    tick(2);

    // lone fetch of the known instruction at 0x10
    if_req = 1; if_addr = 32'h10; tick(3);
    if_req = 0; tick(2);

    // contention: MEM load wins, IF follows once the port frees up
    if_req = 1; if_addr = 32'h14;
    mem_req = 1; mem_we = 0; mem_addr = 32'h40; tick(3);
    mem_req = 0; tick(3);
    if_req = 0; tick(2);

    // store then load-back of the same word
    mem_req = 1; mem_we = 1; mem_addr = 32'h20; mem_wdata = 32'hDEAD_BEEF; tick(3);
    mem_we = 0; tick(3);
    mem_req = 0; tick(2);

    // flush mid-fetch, redirect to 0x80
    if_req = 1; if_addr = 32'h30; tick(1);
    if_flush = 1; if_addr = 32'h80; tick(1);
    if_flush = 0; tick(4);
    if_req = 0; tick(2);

    // flush exactly in the completion cycle, then the fetch is re-issued
    if_req = 1; if_addr = 32'h34; tick(2);
    if_flush = 1; tick(1);
    if_flush = 0; tick(3);
    if_req = 0; tick(2);

    // reset during a load; request held through reset is granted right after
    mem_req = 1; mem_we = 0; mem_addr = 32'h44; tick(1);
    rst = 1; tick(2);
    rst = 0; tick(3);
    mem_req = 0; tick(2);

    // randomized traffic
    for (int n = 0; n < 3000; n++) begin
      rst      = ($urandom_range(0, 199) == 0);
      if_flush = ($urandom_range(0, 11) == 0);
      if (!if_req) begin
        if ($urandom_range(0, 2) == 0) begin
          if_req  = 1;
          if_addr = 32'h400 + ($urandom_range(0, 255) << 2);
        end
      end else if (saw_if_rdy) begin
        if ($urandom_range(0, 1) == 1) if_addr = 32'h400 + ($urandom_range(0, 255) << 2);
        else if_req = 0;
      end else if (if_flush && $urandom_range(0, 1) == 1) begin
        if_addr = 32'h400 + ($urandom_range(0, 255) << 2);
      end
      if (!mem_req || saw_mem_rdy) begin
        if ($urandom_range(0, 2) == 0 || (mem_req && $urandom_range(0, 1) == 1)) begin
          mem_req   = 1;
          mem_we    = 1'($urandom_range(0, 1));
          mem_addr  = 32'h1000 + ($urandom_range(0, 15) << 2);
          mem_wdata = $urandom;
        end else begin
          mem_req = 0;
        end
      end
      tick(1);
    end

    rst = 0; if_req = 0; mem_req = 0; if_flush = 0;
    tick(LAT + 3);
    chk("if_queue_drained", if_q.size(), 0);
    chk("mem_queue_drained", mem_q.size(), 0);
    chk("lat_sweep_done", b_done, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
